clkdiv_multi: RTL and testbench

Multi-channel fractional clock-enable generator, the parametrised successor to the single-channel `clockdiv`. It derives CHANNELS independent `hold` strobes from the one system clock (`clock_cpu`, 25 MHz), for example CPU 3.5/4.3 MHz, AY clock and tape timing. Each channel runs a Bresenham accumulator, so over time it produces exactly `freq` strobes per `fref` clock cycles. Unlike `clockdiv`, each channel's ratio can be reprogrammed at run time through a load handshake, and channels can be re-phased together.

---
 rtl/clkdiv_pkg.sv | 8 +
 rtl/clkdiv_chan.sv | 58 +++++
 rtl/clkdiv_multi.sv | 51 +++++
 tb/tb_clkdiv_multi.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants for the multi-channel fractional clock-enable generator.
// Reset ratio 43/250 gives 4.3 MHz enables from the 25 MHz system clock.
package clkdiv_pkg;
  localparam int ACC_W_DEF    = 16;
  localparam int RST_FREQ     = 43;
  localparam int RST_FREQ_REF = 250;
  localparam int MAX_CHANNELS = 8;
endpackage

// File: rtl/clkdiv_chan.sv
// One Bresenham enable channel: ratio registers, accumulator, saturation and
// load acknowledge. sync_clr re-phases the accumulator without touching the ratio.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             active,
  input  logic             load,
  input  logic             sync_clr,
  input  logic [ACC_W-1:0] freq,
  input  logic [ACC_W-1:0] fref,
  output logic             hold,
  output logic             loaded
);

  logic [ACC_W-1:0] r_freq, r_fref, acc, acc_nxt;
  logic [ACC_W:0]   sum;
  logic             hold_nxt, sat;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, r_freq};
    sat      = !active || (r_freq >= r_fref) || (r_fref == '0);
    hold_nxt = 1'b0;
    acc_nxt  = sum[ACC_W-1:0];
    if (sat) begin
      hold_nxt = 1'b1;
      acc_nxt  = '0;
    end else if (sum >= {1'b0, r_fref}) begin
      // sum < 2*r_fref here, so the difference always fits in ACC_W bits
      hold_nxt = 1'b1;
      acc_nxt  = sum[ACC_W-1:0] - r_fref;
    end
    // hold above still reflects the old ratio / phase; only acc restarts
    if (load || (sync_clr && active)) acc_nxt = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_freq <= ACC_W'(RST_FREQ);
      r_fref <= ACC_W'(RST_FREQ_REF);
      acc    <= '0;
      hold   <= 1'b0;
      loaded <= 1'b0;
    end else begin
      acc    <= acc_nxt;
      hold   <= hold_nxt;
      loaded <= load;
      if (load) begin
        r_freq <= freq;
        r_fref <= fref;
      end
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// CHANNELS independent fractional enable strobes from one clock.
// CLKDIV_MULTI_SYNC_EN adds a `sync` input whose rising edge re-phases all active channels.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
`ifdef CLKDIV_MULTI_SYNC_EN
  input  logic                      sync,
`endif
  input  logic [CHANNELS-1:0]       active,
  input  logic [CHANNELS*ACC_W-1:0] freq,
  input  logic [CHANNELS*ACC_W-1:0] fref,
  input  logic [CHANNELS-1:0]       load,
  output logic [CHANNELS-1:0]       loaded,
  output logic [CHANNELS-1:0]       hold
);

  logic sync_rise;

`ifdef CLKDIV_MULTI_SYNC_EN
  logic sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= 1'b0;
    else          sync_q <= sync;
  end

  assign sync_rise = sync && !sync_q;
`else
  assign sync_rise = 1'b0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clkdiv_chan #(.ACC_W(ACC_W)) u_chan (
      .clock    (clock),
      .reset_n  (reset_n),
      .active   (active[i]),
      .load     (load[i]),
      .sync_clr (sync_rise),
      .freq     (freq[i*ACC_W +: ACC_W]),
      .fref     (fref[i*ACC_W +: ACC_W]),
      .hold     (hold[i]),
      .loaded   (loaded[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: reference model feeds a scoreboard,
// plus per-scenario pulse-count and phase checks.
module tb_clkdiv_multi;
  localparam int CH = 3;
  localparam int W  = 16;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [CH-1:0]   active = '1;
  logic [CH-1:0]   load = '0;
  logic [CH*W-1:0] freq = '0;
  logic [CH*W-1:0] fref = '0;
  logic [CH-1:0]   loaded, hold;
`ifdef CLKDIV_MULTI_SYNC_EN
  logic            sync = 1'b0;
  bit              m_sync_q;
`endif

  always #5 clock = ~clock;

  clkdiv_multi #(.CHANNELS(CH), .ACC_W(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
`ifdef CLKDIV_MULTI_SYNC_EN
    .sync    (sync),
`endif
    .active  (active),
    .freq    (freq),
    .fref    (fref),
    .load    (load),
    .loaded  (loaded),
    .hold    (hold)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_freq[CH], m_fref[CH], m_acc[CH];
  logic [2*CH-1:0] sb[$];

  // scoreboard: one expected {loaded,hold} per edge, checked 1 time unit after it
  always @(posedge clock) begin
    logic [2*CH-1:0] exp_v;
    #1;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      n_checks++;
      if ({loaded, hold} !== exp_v) begin
        n_fail++;
        $display("FAIL sb t=%0t {loaded,hold} actual=%b expected=%b", $time, {loaded, hold}, exp_v);
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_freq[i] = 43;
      m_fref[i] = 250;
      m_acc[i]  = 0;
    end
`ifdef CLKDIV_MULTI_SYNC_EN
    m_sync_q = 1'b0;
`endif
  endfunction

  // evaluate the model for the coming edge, queue its prediction, then cross the edge
  task automatic step();
    logic [CH-1:0] eh, el;
    bit srise;
    srise = 1'b0;
`ifdef CLKDIV_MULTI_SYNC_EN
    srise    = sync && !m_sync_q;
    m_sync_q = sync;
`endif
    for (int i = 0; i < CH; i++) begin
      int s;
      s = m_acc[i] + m_freq[i];
      if (!active[i] || m_freq[i] >= m_fref[i] || m_fref[i] == 0) begin
        eh[i] = 1'b1; m_acc[i] = 0;
      end else if (s >= m_fref[i]) begin
        eh[i] = 1'b1; m_acc[i] = s - m_fref[i];
      end else begin
        eh[i] = 1'b0; m_acc[i] = s;
      end
      if (srise && active[i]) m_acc[i] = 0;
      el[i] = load[i];
      if (load[i]) begin
        m_freq[i] = int'(freq[i*W +: W]);
        m_fref[i] = int'(fref[i*W +: W]);
        m_acc[i]  = 0;
      end
    end
    sb.push_back({el, eh});
    @(posedge clock);
    #2;
  endtask

  task automatic set_ratio(input int ch, input int f, input int r);
    freq[ch*W +: W] = W'(f);
    fref[ch*W +: W] = W'(r);
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (hold !== '0 || loaded !== '0) begin
      n_fail++;
      $display("FAIL reset_state hold=%b loaded=%b required 0/0", hold, loaded);
    end
    repeat (2) @(negedge clock);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_default();
    int cnt, first, adj;
    bit prev;
    cnt = 0; first = -1; adj = 0; prev = 1'b0;
    for (int k = 1; k <= 2500; k++) begin
      step();
      if (hold[0]) begin
        cnt++;
        if (first < 0) first = k;
        if (prev) adj++;
      end
      prev = hold[0];
    end
    n_checks++;
    if (cnt !== 430) begin n_fail++; $display("FAIL default_count actual=%0d required=430", cnt); end
    n_checks++;
    if (first !== 6) begin n_fail++; $display("FAIL default_first_edge actual=%0d required=6", first); end
    n_checks++;
    if (adj !== 0) begin n_fail++; $display("FAIL default_adjacent actual=%0d required=0", adj); end
  endtask

  task automatic test_bypass();
    int cnt, first;
    cnt = 0; first = -1;
    active[1] = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (hold[1]) cnt++;
    end
    active[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (hold[1] && first < 0) first = k;
    end
    n_checks++;
    if (cnt !== 100) begin n_fail++; $display("FAIL bypass_hold actual=%0d required=100", cnt); end
    n_checks++;
    if (first !== 6) begin n_fail++; $display("FAIL bypass_restart_edge actual=%0d required=6", first); end
  endtask

  task automatic test_saturation();
    int tf[3] = '{250, 300, 250};
    int tr[3] = '{250, 250, 0};
    for (int t = 0; t < 3; t++) begin
      int cnt_h, cnt_l;
      set_ratio(2, tf[t], tr[t]);
      load[2] = 1'b1;
      step();
      load[2] = 1'b0;
      cnt_l = int'(loaded[2]);
      cnt_h = 0;
      for (int k = 0; k < 30; k++) begin
        step();
        cnt_l += int'(loaded[2]);
        cnt_h += int'(hold[2]);
      end
      n_checks++;
      if (cnt_h !== 30) begin n_fail++; $display("FAIL sat%0d_hold actual=%0d required=30", t, cnt_h); end
      n_checks++;
      if (cnt_l !== 1) begin n_fail++; $display("FAIL sat%0d_loaded actual=%0d required=1", t, cnt_l); end
    end
  endtask

  task automatic test_load_strobe();
    logic [6:0] pat;
    logic [6:0] req_pat;
    bit ld;
    req_pat = 7'b1010101;
    set_ratio(0, 43, 250);
    load[0] = 1'b1;
    step();
    load[0] = 1'b0;
    repeat (5) step();
    set_ratio(0, 1, 2);
    load[0] = 1'b1;
    step();
    load[0] = 1'b0;
    pat[6] = hold[0];
    ld = loaded[0];
    for (int k = 5; k >= 0; k--) begin
      step();
      pat[k] = hold[0];
    end
    n_checks++;
    if (pat !== req_pat) begin n_fail++; $display("FAIL load_strobe_pattern actual=%b required=%b", pat, req_pat); end
    n_checks++;
    if (ld !== 1'b1) begin n_fail++; $display("FAIL load_strobe_loaded actual=%b required=1", ld); end
  endtask

  task automatic test_reset_mid();
    int first;
    first = -1;
    repeat (37) step();
    set_ratio(0, 1, 2);
    load = '1;
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (hold !== '0 || loaded !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async hold=%b loaded=%b required 0/0", hold, loaded);
    end
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (hold !== '0 || loaded !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_held hold=%b loaded=%b required 0/0", hold, loaded);
    end
    load = '0;
    #2;
    model_reset();
    reset_n = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (hold[0] && first < 0) first = k;
    end
    n_checks++;
    if (first !== 6) begin n_fail++; $display("FAIL reset_mid_restart actual=%0d required=6", first); end
  endtask

  task automatic test_back_to_back();
    int c0, c1, c2;
    bit [CH-1:0] ld;
    c0 = 0; c1 = 0; c2 = 0;
    set_ratio(0, 3, 7);
    set_ratio(1, 5, 16);
    set_ratio(2, 0, 9);
    load = '1;
    step();
    load = '0;
    ld = loaded;
    for (int k = 1; k <= 70; k++) begin
      step();
      c0 += int'(hold[0]);
      if (k <= 64) c1 += int'(hold[1]);
      c2 += int'(hold[2]);
    end
    n_checks++;
    if (ld !== 3'b111) begin n_fail++; $display("FAIL b2b_loaded actual=%b required=111", ld); end
    n_checks++;
    if (c0 !== 30) begin n_fail++; $display("FAIL b2b_ch0_count actual=%0d required=30", c0); end
    n_checks++;
    if (c1 !== 20) begin n_fail++; $display("FAIL b2b_ch1_count actual=%0d required=20", c1); end
    n_checks++;
    if (c2 !== 0) begin n_fail++; $display("FAIL b2b_ch2_count actual=%0d required=0", c2); end
    // random reprogramming traffic, covered by the scoreboard
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < CH; i++) begin
        load[i] = ($urandom_range(0, 7) == 0);
        if (load[i]) set_ratio(i, $urandom_range(0, 20), $urandom_range(0, 24));
        if ($urandom_range(0, 31) == 0) active[i] = ~active[i];
      end
      step();
    end
    load = '0;
    active = '1;
    step();
  endtask

`ifdef CLKDIV_MULTI_SYNC_EN
  task automatic test_sync();
    int f0, f1;
    f0 = -1; f1 = -1;
    for (int i = 0; i < CH; i++) set_ratio(i, 43, 250);
    load = '1;
    step();
    load = '0;
    repeat (3) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (hold[0] && f0 < 0) f0 = k;
      if (hold[1] && f1 < 0) f1 = k;
    end
    n_checks++;
    if (f0 !== 6) begin n_fail++; $display("FAIL sync_ch0_restart actual=%0d required=6", f0); end
    n_checks++;
    if (f1 !== 6) begin n_fail++; $display("FAIL sync_ch1_restart actual=%0d required=6", f1); end
  endtask
`endif

  initial begin
    for (int i = 0; i < CH; i++) set_ratio(i, 43, 250);
    test_reset();
    test_default();
    test_bypass();
    test_saturation();
    test_load_strobe();
    test_reset_mid();
    test_back_to_back();
`ifdef CLKDIV_MULTI_SYNC_EN
    test_sync();
`endif
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
